bnn_psum_threshold: RTL and testbench
=====================================

// Module: bnn_psum_threshold
// PURPOSE
//  Downstream of the XNOR_CONV PE array: accepts per-column popcount psums, accumulates them over
//  a configured number of passes (input-channel tiles), then binarises each lane against a
//  per-lane threshold (folded BatchNorm + sign). Emits one LANES-bit activation word per window.
// PARAMETERS
//  LANES       4   parallel psum lanes (one per PE-array column)
//  PSUM_WIDTH  4   width of each incoming psum (matches PE pcountout)
//  ACC_WIDTH   12  per-lane accumulator and threshold width, unsigned
//  PASS_W      8   width of the pass-count configuration
// PORTS
//  clk         in   1                   clock, rising edge
//  rst         in   1                   asynchronous reset, active-low
//  cfg_we      in   1                   config write strobe
//  cfg_lane    in   $clog2(LANES)       lane index for cfg_thresh/cfg_invert
//  cfg_thresh  in   ACC_WIDTH           threshold value for cfg_lane
//  cfg_invert  in   1                   compare-invert bit for cfg_lane (used only with macro)
//  cfg_passes  in   PASS_W              psum beats per window (sampled on cfg_we)
//  psum_valid  in   1                   psum_in valid
//  psum_ready  out  1                   block can accept psum_in
//  psum_in     in   LANES*PSUM_WIDTH    lane i at [i*PSUM_WIDTH +: PSUM_WIDTH]
//  act_valid   out  1                   act_out valid
//  act_ready   in   1                   consumer accepts act_out
//  act_out     out  LANES               binary activation, bit i = lane i
//  busy        out  1                   high in ACC or EMIT
//  ovf         out  1                   sticky: some lane accumulator saturated
// BEHAVIOUR
//  - Reset (async, rst=0): state IDLE; acc, thresholds, invert bits, pass counter cleared;
//    passes reg = 1; psum_ready=0 while rst=0, then 1; act_valid=0; act_out=0; busy=0; ovf=0.
//  - FSM: IDLE -> ACC on first accepted beat; ACC -> EMIT on beat number passes;
//    EMIT -> IDLE when act_valid && act_ready. If passes==1, IDLE -> EMIT directly.
//  - psum_ready = 1 in IDLE and ACC, 0 in EMIT. Beat accepted iff psum_valid && psum_ready.
//  - First beat of a window loads acc[i] = zero-extended psum; later beats add. Sum is
//    saturating: on carry-out acc[i] = all-ones and ovf set (sticky until reset).
//  - pass counter counts accepted beats, resets to 0 on entering IDLE.
//  - EMIT entered the cycle after last beat accepted (latency 1 clk); act_out registered then:
//    act_out[i] = (acc[i] >= thresh[i]). act_out/act_valid held stable until act_ready.
//  - cfg_passes==0 written -> stored as 1. Config writes honoured only in IDLE with no
//    beat accepted in the same cycle; otherwise silently dropped (no partial updates).
//  - cfg_lane >= LANES: thresh/invert write ignored; cfg_passes still stored.
//  - Simultaneous act_ready handshake in EMIT and psum_valid: beat not accepted that cycle;
//    accepted the next cycle in IDLE (no bubble beyond one clock).
//  - rst asserted mid-window: window discarded, no act_valid produced.
// CONFIGURATION
//  THRESH_INVERT_EN defined: per-lane invert bit stored; if set, act_out[i] = (acc[i] < thresh[i])
//   (negative BatchNorm gamma). Not defined: cfg_invert ignored, no invert storage,
//   compare always acc >= thresh.
// TESTING
//  1 reset: rst=0 mid-sim -> act_valid=0, busy=0, ovf=0 immediately; psum_ready=1 after release.
//  2 passes=3, thresh all 10, beats lane0 {4,4,4}, lane1 {3,3,3} -> act_out[1:0]=2'b01, 1 clk after beat 3.
//  3 backpressure: act_ready=0 for 5 clks in EMIT -> act_out stable, psum_ready=0, no beat lost.
//  4 saturation: ACC_WIDTH=4 lane0 beats {15,15} passes=2 -> acc=15, ovf=1, stays 1 after next window.
//  5 cfg_we during ACC with thresh=0 -> ignored; result uses old threshold; cfg_passes=0 -> 1-beat windows.
//  6 THRESH_INVERT_EN: lane0 invert=1, thresh=8, acc=5 -> act_out[0]=1; without macro -> 0.

Source files
------------

// File: rtl/bnn_psum_threshold.sv
// Accumulates per-lane psums over a window of passes, then binarises each lane against its threshold; act_out 1 clk after last beat.
// psum_ready drops while the result waits in EMIT for act_ready; THRESH_INVERT_EN adds a per-lane compare-invert bit.
module bnn_psum_threshold #(
   parameter int LANES      = 4,
   parameter int PSUM_WIDTH = 4,
   parameter int ACC_WIDTH  = 12,
   parameter int PASS_W     = 8,
   localparam int LW        = (LANES > 1) ? $clog2(LANES) : 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        cfg_we,
   input  logic [LW-1:0]               cfg_lane,
   input  logic [ACC_WIDTH-1:0]        cfg_thresh,
   input  logic                        cfg_invert,
   input  logic [PASS_W-1:0]           cfg_passes,
   input  logic                        psum_valid,
   output logic                        psum_ready,
   input  logic [LANES*PSUM_WIDTH-1:0] psum_in,
   output logic                        act_valid,
   input  logic                        act_ready,
   output logic [LANES-1:0]            act_out,
   output logic                        busy,
   output logic                        ovf
);

   typedef enum logic [1:0] {IDLE, ACC, EMIT} state_t;

   state_t                state, state_nxt;
   logic [ACC_WIDTH-1:0]  acc     [LANES];
   logic [ACC_WIDTH-1:0]  acc_nxt [LANES];
   logic [ACC_WIDTH-1:0]  thresh  [LANES];
   logic [PASS_W-1:0]     pass_cnt;
   logic [PASS_W-1:0]     passes;
   logic                  accept;
   logic                  last;
   logic                  cfg_ok;
   logic                  ovf_hit;
   logic [LANES-1:0]      cmp;
   logic [ACC_WIDTH:0]    sum;
   logic [ACC_WIDTH:0]    lane_ext;

`ifdef THRESH_INVERT_EN
   logic [LANES-1:0]      inv;
`else
   logic                  unused_cfg_invert;
   assign unused_cfg_invert = cfg_invert;
`endif

   assign psum_ready = rst & (state != EMIT);
   assign act_valid  = (state == EMIT);
   assign busy       = (state != IDLE);
   assign accept     = psum_valid & psum_ready;
   assign last       = (pass_cnt == passes - PASS_W'(1));
   // A config write racing a beat would change the window it belongs to, so it is dropped.
   assign cfg_ok     = cfg_we & (state == IDLE) & ~accept;

   always_comb begin
      acc_nxt  = acc;
      ovf_hit  = 1'b0;
      cmp      = '0;
      sum      = '0;
      lane_ext = '0;
      for (int i = 0; i < LANES; i++) begin
         lane_ext = (ACC_WIDTH+1)'(psum_in[i*PSUM_WIDTH +: PSUM_WIDTH]);
         sum      = ((state == IDLE) ? '0 : {1'b0, acc[i]}) + lane_ext;
         if (sum[ACC_WIDTH]) begin
            acc_nxt[i] = '1;
            ovf_hit    = 1'b1;
         end else begin
            acc_nxt[i] = sum[ACC_WIDTH-1:0];
         end
`ifdef THRESH_INVERT_EN
         cmp[i] = inv[i] ? (acc_nxt[i] < thresh[i]) : (acc_nxt[i] >= thresh[i]);
`else
         cmp[i] = (acc_nxt[i] >= thresh[i]);
`endif
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = last ? EMIT : ACC;
         ACC:     if (accept && last) state_nxt = EMIT;
         EMIT:    if (act_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         pass_cnt <= '0;
         passes   <= PASS_W'(1);
         ovf      <= 1'b0;
         act_out  <= '0;
         for (int i = 0; i < LANES; i++) begin
            acc[i]    <= '0;
            thresh[i] <= '0;
         end
`ifdef THRESH_INVERT_EN
         inv      <= '0;
`endif
      end else begin
         state <= state_nxt;
         if (accept) begin
            for (int i = 0; i < LANES; i++) acc[i] <= acc_nxt[i];
            if (ovf_hit) ovf <= 1'b1;
            if (last) act_out <= cmp;
         end
         if (act_valid && act_ready) pass_cnt <= '0;
         else if (accept)            pass_cnt <= pass_cnt + PASS_W'(1);
         if (cfg_ok) begin
            passes <= (cfg_passes == '0) ? PASS_W'(1) : cfg_passes;
            if (int'(cfg_lane) < LANES) begin
               thresh[cfg_lane] <= cfg_thresh;
`ifdef THRESH_INVERT_EN
               inv[cfg_lane]    <= cfg_invert;
`endif
            end
         end
      end
   end

endmodule

// File: tb/tb_bnn_psum_threshold.sv
// Directed bench for bnn_psum_threshold: a 12-bit-accumulator instance plus a 4-bit one for saturation,
// with a scoreboard queue of expected activation words fed by a behavioural accumulate/threshold model.
module tb_bnn_psum_threshold;

   logic        clk = 1'b0;
   logic        rst;
   logic        cfg_we;
   logic [1:0]  cfg_lane;
   logic [11:0] cfg_thresh;
   logic [3:0]  cfg_thresh_s;
   logic        cfg_invert;
   logic [7:0]  cfg_passes;
   logic        psum_valid;
   logic        psum_ready, psum_ready_s;
   logic [15:0] psum_in;
   logic        act_valid, act_valid_s;
   logic        act_ready;
   logic [3:0]  act_out, act_out_s;
   logic        busy, busy_s;
   logic        ovf, ovf_s;

   int tests = 0;
   int fails = 0;

   int         m_thr [4];
   bit         m_inv [4];
   int         m_acc [4];
   int         m_passes;
   int         m_cnt;
   logic [3:0] exp_q [$];

   assign cfg_thresh_s = cfg_thresh[3:0];

   always #5 clk = ~clk;

   bnn_psum_threshold dut (
      .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_lane(cfg_lane), .cfg_thresh(cfg_thresh),
      .cfg_invert(cfg_invert), .cfg_passes(cfg_passes), .psum_valid(psum_valid),
      .psum_ready(psum_ready), .psum_in(psum_in), .act_valid(act_valid), .act_ready(act_ready),
      .act_out(act_out), .busy(busy), .ovf(ovf)
   );

   bnn_psum_threshold #(.ACC_WIDTH(4)) dut_s (
      .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_lane(cfg_lane), .cfg_thresh(cfg_thresh_s),
      .cfg_invert(cfg_invert), .cfg_passes(cfg_passes), .psum_valid(psum_valid),
      .psum_ready(psum_ready_s), .psum_in(psum_in), .act_valid(act_valid_s), .act_ready(act_ready),
      .act_out(act_out_s), .busy(busy_s), .ovf(ovf_s)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] model_word();
      logic [3:0] w;
      w = '0;
      for (int i = 0; i < 4; i++) begin
         w[i] = (m_acc[i] >= m_thr[i]);
`ifdef THRESH_INVERT_EN
         if (m_inv[i]) w[i] = (m_acc[i] < m_thr[i]);
`endif
      end
      return w;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         m_thr[i] = 0;
         m_inv[i] = 1'b0;
         m_acc[i] = 0;
      end
      m_passes = 1;
      m_cnt    = 0;
      exp_q.delete();
   endtask

   // apply=0 marks a write the design is expected to drop.
   task automatic cfg_write(input int lane, input int thr, input bit inv, input int passes, input bit apply);
      cfg_we     = 1'b1;
      cfg_lane   = 2'(lane);
      cfg_thresh = 12'(thr);
      cfg_invert = inv;
      cfg_passes = 8'(passes);
      @(posedge clk); #1;
      cfg_we     = 1'b0;
      if (apply) begin
         m_thr[lane] = thr;
         m_inv[lane] = inv;
         m_passes    = (passes == 0) ? 1 : passes;
      end
   endtask

   task automatic send_beat(input int p0, input int p1, input int p2, input int p3);
      int n;
      int p [4];
      p = '{p0, p1, p2, p3};
      psum_in    = {4'(p3), 4'(p2), 4'(p1), 4'(p0)};
      psum_valid = 1'b1;
      n = 0;
      while (!psum_ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check("psum_ready_wait", psum_ready, 1);
      @(posedge clk); #1;
      psum_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         m_acc[i] = ((m_cnt == 0) ? 0 : m_acc[i]) + p[i];
         if (m_acc[i] > 4095) m_acc[i] = 4095;
      end
      m_cnt++;
      if (m_cnt == m_passes) begin
         exp_q.push_back(model_word());
         m_cnt = 0;
      end
   endtask

   task automatic wait_act(input int hold);
      int n;
      logic [3:0] snap, exp;
      n = 0;
      while (!act_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check("act_valid_wait", act_valid, 1);
      check("exp_q_nonempty", exp_q.size(), 1);
      exp  = (exp_q.size() > 0) ? exp_q.pop_front() : 4'hx;
      snap = act_out;
      check("act_out", act_out, exp);
      act_ready = 1'b0;
      for (int k = 0; k < hold; k++) begin
         @(posedge clk); #1;
         check("bp_act_out_stable", act_out, snap);
         check("bp_act_valid", act_valid, 1);
         check("bp_psum_ready", psum_ready, 0);
      end
      act_ready = 1'b1;
      @(posedge clk); #1;
      act_ready = 1'b0;
      check("act_valid_drop", act_valid, 0);
      check("busy_drop", busy, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout tests=%0d", tests);
      $fatal(1);
   end

   initial begin
      logic exp6;
      rst = 1'b0; cfg_we = 1'b0; cfg_lane = '0; cfg_thresh = '0; cfg_invert = 1'b0;
      cfg_passes = '0; psum_valid = 1'b0; psum_in = '0; act_ready = 1'b0;
      model_reset();

      // reset state
      #12;
      check("rst_psum_ready", psum_ready, 0);
      check("rst_act_valid", act_valid, 0);
      check("rst_act_out", act_out, 0);
      check("rst_busy", busy, 0);
      check("rst_ovf", ovf, 0);
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      check("rel_psum_ready", psum_ready, 1);
      check("rel_busy", busy, 0);

      // 3-pass window, thresholds 10
      for (int i = 0; i < 4; i++) cfg_write(i, 10, 1'b0, 3, 1'b1);
      send_beat(4, 3, 0, 0);
      check("acc_busy", busy, 1);
      check("acc_no_act", act_valid, 0);
      send_beat(4, 3, 0, 0);
      send_beat(4, 3, 0, 0);
      check("lat1_act_valid", act_valid, 1);
      check("lat1_act_out", act_out, 4'b0001);
      check("emit_psum_ready", psum_ready, 0);
      wait_act(0);

      // backpressure with a beat of the next window pending
      send_beat(1, 5, 4, 0);
      send_beat(2, 5, 4, 0);
      send_beat(3, 5, 3, 9);
      psum_in    = {4'd0, 4'd0, 4'd1, 4'd5};
      psum_valid = 1'b1;
      wait_act(5);
      check("post_hs_psum_ready", psum_ready, 1);
      send_beat(5, 1, 0, 0);
      send_beat(3, 1, 0, 0);
      check("w2_not_done", act_valid, 0);
      send_beat(3, 1, 0, 0);
      wait_act(0);
      check("pre_sat_ovf_s", ovf_s, 0);

      // saturation on the 4-bit instance
      cfg_write(0, 10, 1'b0, 2, 1'b1);
      send_beat(15, 0, 0, 0);
      send_beat(15, 0, 0, 0);
      check("sat_act_out_s", act_out_s, 4'b0001);
      check("sat_ovf_s", ovf_s, 1);
      check("wide_ovf", ovf, 0);
      wait_act(0);

      // config during ACC is dropped; passes=0 becomes 1
      cfg_write(0, 10, 1'b0, 3, 1'b1);
      send_beat(1, 12, 0, 0);
      cfg_write(0, 0, 1'b0, 0, 1'b0);
      send_beat(1, 0, 0, 0);
      check("cfg_drop_not_done", act_valid, 0);
      send_beat(1, 0, 0, 0);
      wait_act(0);
      cfg_write(0, 10, 1'b0, 0, 1'b1);
      send_beat(15, 12, 0, 0);
      check("pass1_act_valid", act_valid, 1);
      wait_act(0);
      check("ovf_s_sticky", ovf_s, 1);

      // compare invert
`ifdef THRESH_INVERT_EN
      exp6 = 1'b1;
`else
      exp6 = 1'b0;
`endif
      cfg_write(0, 8, 1'b1, 1, 1'b1);
      send_beat(5, 0, 0, 0);
      check("invert_lane0", act_out[0], exp6);
      wait_act(0);

      // reset mid-window discards it
      cfg_write(0, 8, 1'b0, 2, 1'b1);
      send_beat(1, 1, 1, 1);
      rst = 1'b0;
      #2;
      check("mid_rst_act_valid", act_valid, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_ovf_s", ovf_s, 0);
      check("mid_rst_psum_ready", psum_ready, 0);
      model_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      check("mid_rel_psum_ready", psum_ready, 1);
      send_beat(3, 0, 7, 0);
      check("post_rst_act_valid", act_valid, 1);
      wait_act(0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
